// File: rtl/count_enable_ctrl_if.sv
// count_enable_ctrl_if: raw buttons in (btn_start_stop, btn_clear); tick/clr pulses, run and state out
interface count_enable_ctrl_if;
  logic btn_start_stop;
  logic btn_clear;
  logic tick;
  logic clr;
  logic run;
  logic [1:0] state;
  modport master (output btn_start_stop, btn_clear, input tick, clr, run, state);
  modport slave (input btn_start_stop, btn_clear, output tick, clr, run, state);
endinterface

// File: rtl/count_enable_ctrl.sv
// count_enable_ctrl: debounced start/stop + clear buttons driving IDLE/RUN/PAUSE FSM, prescaled tick and clr pulses; ports clk, reset, bus (slave)
module count_enable_ctrl #(
  parameter int PRESCALE = 100000,
  parameter int DEBOUNCE = 16
) (
  input logic clk,
  input logic reset,
  count_enable_ctrl_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int DW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, BAD = 2'b11} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0] s1_q, s2_q, db_q, db_d, db_prev_q, press;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic tick_q, tick_d, clr_q, clr_d;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (s2_q[i] == db_q[i] || cnt_q[i] == DMAX) ? '0 : cnt_q[i] + 1'b1;
      db_d[i] = (s2_q[i] != db_q[i] && cnt_q[i] == DMAX) ? s2_q[i] : db_q[i];
    end
    press = db_q & ~db_prev_q;
    state_d = (state_q == BAD || press[1]) ? IDLE : press[0] ? (state_q == RUN ? PAUSE : RUN) : state_q;
    pre_d = (press[1] || state_q == IDLE || state_q == BAD) ? '0 :
            state_q == PAUSE ? pre_q : pre_q == PMAX ? '0 : pre_q + 1'b1;
    tick_d = state_q == RUN && pre_q == PMAX && !press[1];
    clr_d = press[1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      db_prev_q <= '0;
      cnt_q <= '{default: '0};
      state_q <= IDLE;
      pre_q <= '0;
      tick_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      s1_q <= {bus.btn_clear, bus.btn_start_stop};
      s2_q <= s1_q;
      db_q <= db_d;
      db_prev_q <= db_q;
      cnt_q <= cnt_d;
      state_q <= state_d;
      pre_q <= pre_d;
      tick_q <= tick_d;
      clr_q <= clr_d;
    end
  end
  assign bus.tick = tick_q;
  assign bus.clr = clr_q;
  assign bus.run = state_q == RUN;
  assign bus.state = state_q;
endmodule
